// File: rtl/mem_arbiter_pkg.sv
// Shared memory-interface types for the processor-memory arbiter and its tag table.
package mem_arbiter_pkg;

  localparam int unsigned DEF_NUM_MEM_TAGS = 15;
  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned BLOCK_W          = 64;
  localparam int unsigned TAG_W            = $clog2(DEF_NUM_MEM_TAGS + 1);

  typedef logic [ADDR_W-1:0]  ADDR;
  typedef logic [BLOCK_W-1:0] MEM_BLOCK;
  typedef logic [TAG_W-1:0]   MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } MEM_COMMAND;

  typedef enum logic {
    OWNER_DCACHE = 1'b0,
    OWNER_ICACHE = 1'b1
  } MEM_OWNER;

  typedef struct packed {
    logic     valid;
    MEM_OWNER owner;
  } MEM_TAG_ENTRY;

endpackage

// File: rtl/mem_tag_table.sv
// Tracks which requester owns each outstanding memory tag and steers responses back to it.
module mem_tag_table
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MEM_TAGS = DEF_NUM_MEM_TAGS
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              set_en,
  input  MEM_TAG                            set_tag,
  input  MEM_OWNER                          set_owner,
  input  MEM_TAG                            rsp_tag,
  output MEM_TAG                            dc_data_tag,
  output MEM_TAG                            ic_data_tag,
  output logic                              orphan_resp,
  output logic [$clog2(NUM_MEM_TAGS+1)-1:0] outstanding
);

  localparam int unsigned CNT_W = $clog2(NUM_MEM_TAGS + 1);

  MEM_TAG_ENTRY     table_q [NUM_MEM_TAGS+1];
  MEM_TAG_ENTRY     table_d [NUM_MEM_TAGS+1];
  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] outstanding_d;
  logic             hit;

  // Entry 0 is never written, so tag 0 can never hit.
  assign hit = (rsp_tag != '0) && (rsp_tag <= MEM_TAG'(NUM_MEM_TAGS)) && table_q[rsp_tag].valid;

  assign dc_data_tag = (hit && table_q[rsp_tag].owner == OWNER_DCACHE) ? rsp_tag : '0;
  assign ic_data_tag = (hit && table_q[rsp_tag].owner == OWNER_ICACHE) ? rsp_tag : '0;
  assign orphan_resp = (rsp_tag != '0) && !hit;
  assign outstanding = outstanding_q;

  // Retire first, then set, so a same-cycle reissue of the retired tag ends valid with the new owner.
  always_comb begin
    for (int unsigned i = 0; i <= NUM_MEM_TAGS; i++) begin
      table_d[i] = table_q[i];
    end
    if (hit) begin
      table_d[rsp_tag].valid = 1'b0;
    end
    if (set_en && set_tag != '0 && set_tag <= MEM_TAG'(NUM_MEM_TAGS)) begin
      table_d[set_tag].valid = 1'b1;
      table_d[set_tag].owner = set_owner;
    end
    outstanding_d = '0;
    for (int unsigned i = 1; i <= NUM_MEM_TAGS; i++) begin
      outstanding_d = outstanding_d + CNT_W'(table_d[i].valid);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i <= NUM_MEM_TAGS; i++) begin
        table_q[i] <= '{valid: 1'b0, owner: OWNER_DCACHE};
      end
      outstanding_q <= '0;
    end else begin
      for (int unsigned i = 0; i <= NUM_MEM_TAGS; i++) begin
        table_q[i] <= table_d[i];
      end
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Grants the single memory port to Dcache or Icache, with an Icache anti-starvation override.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MEM_TAGS = DEF_NUM_MEM_TAGS,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  MEM_COMMAND                        dc_command,
  input  ADDR                               dc_addr,
  input  MEM_BLOCK                          dc_data,
  input  MEM_COMMAND                        ic_command,
  input  ADDR                               ic_addr,
  input  MEM_TAG                            mem2proc_transaction_tag,
  input  MEM_BLOCK                          mem2proc_data,
  input  MEM_TAG                            mem2proc_data_tag,
  output MEM_COMMAND                        proc2mem_command,
  output ADDR                               proc2mem_addr,
  output MEM_BLOCK                          proc2mem_data,
  output MEM_TAG                            dc_transaction_tag,
  output MEM_TAG                            ic_transaction_tag,
  output MEM_TAG                            dc_data_tag,
  output MEM_TAG                            ic_data_tag,
  output MEM_BLOCK                          resp_data,
  output logic [$clog2(NUM_MEM_TAGS+1)-1:0] outstanding,
  output logic                              orphan_resp
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          dc_req;
  logic          ic_req;
  logic          dc_win;
  logic          ic_win;
  logic          accepted;

  assign dc_req   = (dc_command != MEM_NONE);
  assign ic_req   = (ic_command != MEM_NONE);
  assign ic_win   = ic_req && (!dc_req || starve_q >= SW'(STARVE_LIMIT));
  assign dc_win   = dc_req && !ic_win;
  assign accepted = (mem2proc_transaction_tag != '0);

  always_comb begin
    proc2mem_command   = MEM_NONE;
    proc2mem_addr      = '0;
    proc2mem_data      = '0;
    dc_transaction_tag = '0;
    ic_transaction_tag = '0;
    if (ic_win) begin
      proc2mem_command   = ic_command;
      proc2mem_addr      = ic_addr;
      ic_transaction_tag = mem2proc_transaction_tag;
    end else if (dc_win) begin
      proc2mem_command   = dc_command;
      proc2mem_addr      = dc_addr;
      proc2mem_data      = dc_data;
      dc_transaction_tag = mem2proc_transaction_tag;
    end
  end

  // A granted Icache fetch that memory refused (tag 0) still counts as a denied cycle.
  always_comb begin
    starve_d = starve_q;
    if (!ic_req || (ic_win && accepted)) begin
      starve_d = '0;
    end else if (starve_q < SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign resp_data = mem2proc_data;

  mem_tag_table #(
    .NUM_MEM_TAGS(NUM_MEM_TAGS)
  ) u_tag_table (
    .clock       (clock),
    .reset       (reset),
    .set_en      (proc2mem_command == MEM_LOAD && accepted),
    .set_tag     (mem2proc_transaction_tag),
    .set_owner   (ic_win ? OWNER_ICACHE : OWNER_DCACHE),
    .rsp_tag     (mem2proc_data_tag),
    .dc_data_tag (dc_data_tag),
    .ic_data_tag (ic_data_tag),
    .orphan_resp (orphan_resp),
    .outstanding (outstanding)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of grant priority, starvation override, tag tracking, orphans and reset.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic       clock;
  logic       reset;
  MEM_COMMAND dc_command;
  ADDR        dc_addr;
  MEM_BLOCK   dc_data;
  MEM_COMMAND ic_command;
  ADDR        ic_addr;
  MEM_TAG     mem2proc_transaction_tag;
  MEM_BLOCK   mem2proc_data;
  MEM_TAG     mem2proc_data_tag;
  MEM_COMMAND proc2mem_command;
  ADDR        proc2mem_addr;
  MEM_BLOCK   proc2mem_data;
  MEM_TAG     dc_transaction_tag;
  MEM_TAG     ic_transaction_tag;
  MEM_TAG     dc_data_tag;
  MEM_TAG     ic_data_tag;
  MEM_BLOCK   resp_data;
  logic [3:0] outstanding;
  logic       orphan_resp;

  int unsigned total;
  int unsigned bad;

  mem_arbiter #(
    .NUM_MEM_TAGS(15),
    .STARVE_LIMIT(4)
  ) dut (
    .clock                    (clock),
    .reset                    (reset),
    .dc_command               (dc_command),
    .dc_addr                  (dc_addr),
    .dc_data                  (dc_data),
    .ic_command               (ic_command),
    .ic_addr                  (ic_addr),
    .mem2proc_transaction_tag (mem2proc_transaction_tag),
    .mem2proc_data            (mem2proc_data),
    .mem2proc_data_tag        (mem2proc_data_tag),
    .proc2mem_command         (proc2mem_command),
    .proc2mem_addr            (proc2mem_addr),
    .proc2mem_data            (proc2mem_data),
    .dc_transaction_tag       (dc_transaction_tag),
    .ic_transaction_tag       (ic_transaction_tag),
    .dc_data_tag              (dc_data_tag),
    .ic_data_tag              (ic_data_tag),
    .resp_data                (resp_data),
    .outstanding              (outstanding),
    .orphan_resp              (orphan_resp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    dc_command = MEM_NONE; dc_addr = '0; dc_data = '0;
    ic_command = MEM_NONE; ic_addr = '0;
    mem2proc_transaction_tag = '0; mem2proc_data = '0; mem2proc_data_tag = '0;
  endtask

  // Advance one edge, then settle just past it before the next drive.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_cmd",   proc2mem_command, MEM_NONE);
    check("rst_dctt",  dc_transaction_tag, 0);
    check("rst_ictt",  ic_transaction_tag, 0);
    check("rst_out",   outstanding, 0);
    check("rst_orph",  orphan_resp, 0);
    check("rst_addr",  proc2mem_addr, 0);

    // Dcache load accepted with tag 3, then its response.
    dc_command = MEM_LOAD; dc_addr = 32'h100; mem2proc_transaction_tag = 4'd3;
    #1;
    check("ld_cmd",  proc2mem_command, MEM_LOAD);
    check("ld_addr", proc2mem_addr, 32'h100);
    check("ld_dctt", dc_transaction_tag, 3);
    check("ld_ictt", ic_transaction_tag, 0);
    tick();
    idle();
    #1;
    check("ld_out1", outstanding, 1);
    mem2proc_data_tag = 4'd3; mem2proc_data = 64'hDEAD_BEEF_0000_0001;
    #1;
    check("rsp_dc",   dc_data_tag, 3);
    check("rsp_ic",   ic_data_tag, 0);
    check("rsp_data", resp_data, 64'hDEAD_BEEF_0000_0001);
    check("rsp_orph", orphan_resp, 0);
    tick();
    idle();
    #1;
    check("rsp_out0", outstanding, 0);

    // Both request continuously: Dcache x4, Icache on the 5th, Dcache again.
    for (int c = 1; c <= 6; c++) begin
      dc_command = MEM_LOAD; dc_addr = 32'h200;
      ic_command = MEM_LOAD; ic_addr = 32'h300;
      mem2proc_transaction_tag = 4'd9;
      #1;
      if (c == 5) begin
        check($sformatf("stv%0d_addr", c), proc2mem_addr, 32'h300);
        check($sformatf("stv%0d_ictt", c), ic_transaction_tag, 9);
        check($sformatf("stv%0d_dctt", c), dc_transaction_tag, 0);
      end else begin
        check($sformatf("stv%0d_addr", c), proc2mem_addr, 32'h200);
        check($sformatf("stv%0d_dctt", c), dc_transaction_tag, 9);
        check($sformatf("stv%0d_ictt", c), ic_transaction_tag, 0);
      end
      tick();
    end
    idle();
    #1;
    check("stv_out", outstanding, 1);
    mem2proc_data_tag = 4'd9;
    #1;
    check("stv_rdc", dc_data_tag, 9);
    check("stv_ric", ic_data_tag, 0);
    tick();
    idle();
    #1;
    check("stv_out0", outstanding, 0);

    // Dcache store accepted with tag 5 is not tracked.
    dc_command = MEM_STORE; dc_addr = 32'h440; dc_data = 64'h1234_5678_9ABC_DEF0;
    mem2proc_transaction_tag = 4'd5;
    #1;
    check("st_cmd",  proc2mem_command, MEM_STORE);
    check("st_data", proc2mem_data, 64'h1234_5678_9ABC_DEF0);
    check("st_dctt", dc_transaction_tag, 5);
    tick();
    idle();
    #1;
    check("st_out", outstanding, 0);
    mem2proc_data_tag = 4'd5;
    #1;
    check("st_orph", orphan_resp, 1);
    check("st_rdc",  dc_data_tag, 0);
    tick();
    idle();
    #1;
    check("st_out2", outstanding, 0);

    // Icache owns tag 2; retire and reissue it to Dcache in the same cycle.
    ic_command = MEM_LOAD; ic_addr = 32'h500; mem2proc_transaction_tag = 4'd2;
    #1;
    check("re_ictt", ic_transaction_tag, 2);
    tick();
    idle();
    #1;
    check("re_out1", outstanding, 1);
    mem2proc_data_tag = 4'd2;
    dc_command = MEM_LOAD; dc_addr = 32'h600; mem2proc_transaction_tag = 4'd2;
    #1;
    check("re_ric",  ic_data_tag, 2);
    check("re_rdc",  dc_data_tag, 0);
    check("re_dctt", dc_transaction_tag, 2);
    tick();
    idle();
    #1;
    check("re_out2", outstanding, 1);
    mem2proc_data_tag = 4'd2;
    #1;
    check("re_rdc2", dc_data_tag, 2);
    check("re_ric2", ic_data_tag, 0);
    tick();
    idle();
    #1;
    check("re_out3", outstanding, 0);

    // Tag issued before reset comes back as an orphan.
    ic_command = MEM_LOAD; ic_addr = 32'h700; mem2proc_transaction_tag = 4'd7;
    #1;
    check("rr_ictt", ic_transaction_tag, 7);
    tick();
    idle();
    #1;
    check("rr_out1", outstanding, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rr_out0", outstanding, 0);
    mem2proc_data_tag = 4'd7;
    #1;
    check("rr_ric",  ic_data_tag, 0);
    check("rr_orph", orphan_resp, 1);
    tick();
    idle();
    #1;
    check("rr_orph0", orphan_resp, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
